// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the game timers (count-up and countdown).
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE     = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    typedef struct packed {
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } digits_t;

    // One-second BCD decrement with borrow chaining; caller guarantees d != 0:00.
    function automatic digits_t digits_dec(digits_t d);
        digits_t r;
        r = d;
        if (d.sec_ones != '0) begin
            r.sec_ones = d.sec_ones - 4'd1;
        end else begin
            r.sec_ones = BCD_NINE;
            if (d.sec_tens != '0) begin
                r.sec_tens = d.sec_tens - 4'd1;
            end else begin
                r.sec_tens = SEC_TENS_MAX;
                r.min_ones = d.min_ones - 4'd1;
            end
        end
        return r;
    endfunction

    // Final 9..1 seconds of a countdown.
    function automatic logic in_warn_window(digits_t d);
        return (d.min_ones == '0) && (d.sec_tens == '0) && (d.sec_ones != '0);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides Clock down to a one-cycle tick every CLK_HZ enabled cycles.
// With COUNTDOWN_WARN_EN defined, also reports which half of the second the next count is in.
module tick_prescaler #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clear,
    input  logic en,
`ifdef COUNTDOWN_WARN_EN
    output logic upper_half,
`endif
    output logic tick
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = RELOAD;
        end else if (en) begin
            if (count_q == '0) begin
                tick    = 1'b1;
                count_d = RELOAD;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef COUNTDOWN_WARN_EN
    localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

    // Looks at the next count so the registered warn lines up with the boundary.
    assign upper_half = (count_d >= HALF);
`endif

endmodule

// File: rtl/countdown_timer.sv
// BCD M:SS countdown timer for the whack-a-mole game; loads a preset on start, signals expiry.
// Optional blinking last-seconds warning output enabled by defining COUNTDOWN_WARN_EN.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned START_MIN = 1,
    parameter int unsigned START_SEC = 0
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       running,
    output logic       time_up,
`ifdef COUNTDOWN_WARN_EN
    output logic       warn,
`endif
    output logic       done_pulse
);

    localparam digits_t PRESET = {bcd_t'(START_MIN), bcd_t'(START_SEC / 10),
                                  bcd_t'(START_SEC % 10)};

    state_e  state_q;
    digits_t dig_q;
    digits_t dig_dec;
    logic    running_q, time_up_q, done_pulse_q;
    logic    load, count_en, tick;

    // abort beats start in every state
    assign load     = start & ~abort;
    assign count_en = (state_q == StRun) & ~pause;
    assign dig_dec  = digits_dec(dig_q);

`ifdef COUNTDOWN_WARN_EN
    logic upper_half;
`endif

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .clear     (load),
        .en        (count_en),
`ifdef COUNTDOWN_WARN_EN
        .upper_half(upper_half),
`endif
        .tick      (tick)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= StIdle;
            dig_q        <= '0;
            running_q    <= 1'b0;
            time_up_q    <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            if (abort) begin
                state_q   <= StIdle;
                dig_q     <= '0;
                running_q <= 1'b0;
                time_up_q <= 1'b0;
            end else if (start) begin
                if (PRESET == '0) begin
                    state_q      <= StDone;
                    dig_q        <= '0;
                    running_q    <= 1'b0;
                    time_up_q    <= 1'b1;
                    done_pulse_q <= 1'b1;
                end else begin
                    state_q   <= StRun;
                    dig_q     <= PRESET;
                    running_q <= 1'b1;
                    time_up_q <= 1'b0;
                end
            end else if (state_q == StRun && tick) begin
                dig_q <= dig_dec;
                if (dig_dec == '0) begin
                    state_q      <= StDone;
                    running_q    <= 1'b0;
                    time_up_q    <= 1'b1;
                    done_pulse_q <= 1'b1;
                end
            end
        end
    end

`ifdef COUNTDOWN_WARN_EN
    logic warn_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            warn_q <= 1'b0;
        end else if (abort) begin
            warn_q <= 1'b0;
        end else if (start) begin
            warn_q <= in_warn_window(PRESET) & ~pause;
        end else if (state_q == StRun) begin
            if (tick) begin
                warn_q <= in_warn_window(dig_dec) & upper_half;
            end else begin
                warn_q <= in_warn_window(dig_q) & upper_half & ~pause;
            end
        end else begin
            warn_q <= 1'b0;
        end
    end

    assign warn = warn_q;
`endif

    assign sec_ones   = dig_q.sec_ones;
    assign sec_tens   = dig_q.sec_tens;
    assign min_ones   = dig_q.min_ones;
    assign running    = running_q;
    assign time_up    = time_up_q;
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer (CLK_HZ=4, preset 0:12 unless noted).
module tb_countdown_timer;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    logic start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic start_b = 1'b0, start_z = 1'b0, zero_l = 1'b0;

    logic [3:0] so, st, mo, so_b, st_b, mo_b, so_z, st_z, mo_z;
    logic running, time_up, done_pulse;
    logic running_b, time_up_b, done_pulse_b;
    logic running_z, time_up_z, done_pulse_z;
`ifdef COUNTDOWN_WARN_EN
    logic warn, warn_b, warn_z;
    logic start_w = 1'b0, pause_w = 1'b0;
    logic [3:0] so_w, st_w, mo_w;
    logic running_w, time_up_w, done_pulse_w, warn_w;
`endif

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    countdown_timer #(.CLK_HZ(4), .START_MIN(0), .START_SEC(12)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .pause(pause), .abort(abort),
        .sec_ones(so), .sec_tens(st), .min_ones(mo), .running(running), .time_up(time_up),
`ifdef COUNTDOWN_WARN_EN
        .warn(warn),
`endif
        .done_pulse(done_pulse)
    );

    countdown_timer #(.CLK_HZ(4), .START_MIN(1), .START_SEC(0)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .start(start_b), .pause(zero_l), .abort(zero_l),
        .sec_ones(so_b), .sec_tens(st_b), .min_ones(mo_b), .running(running_b),
        .time_up(time_up_b),
`ifdef COUNTDOWN_WARN_EN
        .warn(warn_b),
`endif
        .done_pulse(done_pulse_b)
    );

    countdown_timer #(.CLK_HZ(4), .START_MIN(0), .START_SEC(0)) dut_z (
        .Clock(Clock), .Resetn(Resetn), .start(start_z), .pause(zero_l), .abort(zero_l),
        .sec_ones(so_z), .sec_tens(st_z), .min_ones(mo_z), .running(running_z),
        .time_up(time_up_z),
`ifdef COUNTDOWN_WARN_EN
        .warn(warn_z),
`endif
        .done_pulse(done_pulse_z)
    );

`ifdef COUNTDOWN_WARN_EN
    countdown_timer #(.CLK_HZ(8), .START_MIN(0), .START_SEC(12)) dut_w (
        .Clock(Clock), .Resetn(Resetn), .start(start_w), .pause(pause_w), .abort(zero_l),
        .sec_ones(so_w), .sec_tens(st_w), .min_ones(mo_w), .running(running_w),
        .time_up(time_up_w), .warn(warn_w), .done_pulse(done_pulse_w)
    );
`endif

    typedef struct {
        logic st, pa, ab;
        int   cyc;
        int   m, t, o;
        logic run, tu, dp;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic s, logic p, logic a, int c, int m, int t, int o,
                                logic r, logic tu, logic dp);
        vec_t v;
        v.st = s; v.pa = p; v.ab = a; v.cyc = c;
        v.m = m; v.t = t; v.o = o; v.run = r; v.tu = tu; v.dp = dp;
        return v;
    endfunction

    function automatic logic [14:0] ex(int m, int t, int o, logic r, logic tu, logic dp);
        return {4'(m), 4'(t), 4'(o), r, tu, dp};
    endfunction

    function automatic logic [14:0] obs();
        return {mo, st, so, running, time_up, done_pulse};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h (M,T,O,run,tu,dp), want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           st pa ab cyc  M  T  O  run tu dp
        vecs[0]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // idle
        vecs[1]  = mk(0, 0, 1, 1,  0, 0, 0, 0, 0, 0);  // abort in idle
        vecs[2]  = mk(1, 0, 0, 1,  0, 1, 2, 1, 0, 0);  // load
        vecs[3]  = mk(0, 0, 0, 3,  0, 1, 2, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1,  0, 1, 1, 1, 0, 0);  // first tick
        vecs[5]  = mk(0, 0, 0, 4,  0, 1, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 4,  0, 0, 9, 1, 0, 0);  // tens borrow
        vecs[7]  = mk(0, 0, 0, 16, 0, 0, 5, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 16, 0, 0, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 3,  0, 0, 1, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 1);  // expiry
        vecs[11] = mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        vecs[12] = mk(0, 1, 0, 1,  0, 0, 0, 0, 1, 0);  // pause ignored in DONE
        vecs[13] = mk(1, 0, 0, 1,  0, 1, 2, 1, 0, 0);  // restart from DONE
        vecs[14] = mk(1, 0, 1, 1,  0, 0, 0, 0, 0, 0);  // start+abort
        vecs[15] = mk(0, 0, 0, 3,  0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, 0, 0, 1,  0, 1, 2, 1, 0, 0);
        vecs[17] = mk(0, 0, 0, 2,  0, 1, 2, 1, 0, 0);
        vecs[18] = mk(1, 0, 0, 1,  0, 1, 2, 1, 0, 0);  // restart in RUN
        vecs[19] = mk(0, 0, 0, 3,  0, 1, 2, 1, 0, 0);
        vecs[20] = mk(0, 0, 0, 1,  0, 1, 1, 1, 0, 0);
        vecs[21] = mk(0, 0, 1, 1,  0, 0, 0, 0, 0, 0);

        step(2);
        check("reset", obs(), ex(0, 0, 0, 0, 0, 0));
        Resetn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            start = vecs[i].st; pause = vecs[i].pa; abort = vecs[i].ab;
            step(1);
            start = 1'b0; pause = 1'b0; abort = 1'b0;
            if (vecs[i].cyc > 1) step(vecs[i].cyc - 1);
            check($sformatf("vec%0d", i), obs(),
                  ex(vecs[i].m, vecs[i].t, vecs[i].o, vecs[i].run, vecs[i].tu, vecs[i].dp));
        end

        // Pause delays the second tick by exactly the paused cycles.
        start = 1'b1; step(1); start = 1'b0;
        step(5);
        check("pause_pre", obs(), ex(0, 1, 1, 1, 0, 0));
        pause = 1'b1; step(10);
        check("pause_hold", obs(), ex(0, 1, 1, 1, 0, 0));
        pause = 1'b0; step(2);
        check("pause_late", obs(), ex(0, 1, 1, 1, 0, 0));
        step(1);
        check("pause_tick", obs(), ex(0, 1, 0, 1, 0, 0));

        // Asynchronous reset between edges at 0:05.
        abort = 1'b1; step(1); abort = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(28);
        check("at_0_05", obs(), ex(0, 0, 5, 1, 0, 0));
        #2 Resetn = 1'b0;
        #1 check("async_rst", obs(), ex(0, 0, 0, 0, 0, 0));
        #1 Resetn = 1'b1;
        step(1);
        check("rst_release", obs(), ex(0, 0, 0, 0, 0, 0));
        step(4);
        check("rst_idle", obs(), ex(0, 0, 0, 0, 0, 0));

        // Preset 1:00: double borrow, 60 ticks to DONE.
        start_b = 1'b1; step(1); start_b = 1'b0;
        check("b_load", {mo_b, st_b, so_b, running_b, time_up_b, done_pulse_b},
              ex(1, 0, 0, 1, 0, 0));
        step(4);
        check("b_borrow", {mo_b, st_b, so_b, running_b, time_up_b, done_pulse_b},
              ex(0, 5, 9, 1, 0, 0));
        step(235);
        check("b_last", {mo_b, st_b, so_b, running_b, time_up_b, done_pulse_b},
              ex(0, 0, 1, 1, 0, 0));
        step(1);
        check("b_done", {mo_b, st_b, so_b, running_b, time_up_b, done_pulse_b},
              ex(0, 0, 0, 0, 1, 1));

        // Preset 0:00 goes straight to DONE.
        start_z = 1'b1; step(1); start_z = 1'b0;
        check("z_done", {mo_z, st_z, so_z, running_z, time_up_z, done_pulse_z},
              ex(0, 0, 0, 0, 1, 1));
        step(1);
        check("z_hold", {mo_z, st_z, so_z, running_z, time_up_z, done_pulse_z},
              ex(0, 0, 0, 0, 1, 0));

`ifdef COUNTDOWN_WARN_EN
        start_w = 1'b1; step(1); start_w = 1'b0;
        step(23);
        check("w_0_10", {mo_w, st_w, so_w, 2'b00, warn_w}, ex(0, 1, 0, 0, 0, 0));
        step(1);
        check("w_rise", {mo_w, st_w, so_w, 2'b00, warn_w}, ex(0, 0, 9, 0, 0, 1));
        step(3);
        check("w_hi", {14'd0, warn_w}, 15'd1);
        step(1);
        check("w_lo", {14'd0, warn_w}, 15'd0);
        step(3);
        check("w_lo2", {14'd0, warn_w}, 15'd0);
        step(1);
        check("w_hi2", {mo_w, st_w, so_w, 2'b00, warn_w}, ex(0, 0, 8, 0, 0, 1));
        pause_w = 1'b1; step(1);
        check("w_pause", {14'd0, warn_w}, 15'd0);
        pause_w = 1'b0;
        for (int k = 0; k < 200 && !time_up_w; k++) step(1);
        check("w_done_reached", {14'd0, time_up_w}, 15'd1);
        check("w_done", {14'd0, warn_w}, 15'd0);
        step(3);
        check("w_done_hold", {14'd0, warn_w}, 15'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
